event_timestamper: RTL and testbench

EVENT_TIMESTAMPER -- requirements
Module: event_timestamper

---
 rtl/event_timestamper.sv | 132 +++++++++++++
 tb/tb_event_timestamper.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_timestamper.sv
`default_nettype none
// ============================================================================
// Module      : event_timestamper
// Description : Edge detector on a debounced level input. Each captured edge
//               is tagged with a free-running timestamp and queued in a small
//               FIFO behind an AXI-Stream style valid/ready handshake. Events
//               arriving while the FIFO is full are dropped and counted in a
//               saturating 16-bit overflow counter.
//               Optional macro EVENT_TIMESTAMPER_FALLING_EDGE_EN additionally
//               captures falling edges (polarity bit 0).
// Revision    : 1.0 - initial release
// ============================================================================
module event_timestamper #(
    parameter int TW    = 32,
    parameter int DEPTH = 8
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          din,
    input  logic          en,
    output logic [TW:0]   m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    input  logic          clr_ovf,
    output logic [15:0]   ovf_cnt
);

    localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0]   C_OVF_MAX = 16'hFFFF;
    localparam logic [TW-1:0] C_TS_ONE  = TW'(1);
    localparam logic [AW:0]   C_PTR_ONE = (AW + 1)'(1);

    // Registered state
    logic              r_din_q;
    logic              r_prime;
    logic [TW-1:0]     r_ts;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [TW:0]       r_mem [DEPTH];
    logic [15:0]       r_ovf_cnt;

    // Combinational decode
    logic              w_rise;
    logic              w_fall;
    logic              w_edge;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // The prime flag blocks an edge against the reset value of din_q, so a
    // level that is already high at reset release is not mistaken for a rise.
    assign w_rise = din & ~r_din_q & r_prime;
`ifdef EVENT_TIMESTAMPER_FALLING_EDGE_EN
    assign w_fall = ~din & r_din_q & r_prime;
`else
    assign w_fall = 1'b0;
`endif
    assign w_edge = en & (w_rise | w_fall);

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bits means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_pop  = ~w_empty & m_tready;
    assign w_push = w_edge & (~w_full | w_pop);
    assign w_drop = w_edge & w_full & ~w_pop;

    // Head is presented straight from storage; zero when nothing is queued.
    assign m_tvalid = ~w_empty;
    assign m_tdata  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign ovf_cnt  = r_ovf_cnt;

    // Input history and prime flag track din regardless of the enable.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_din_q <= 1'b0;
            r_prime <= 1'b0;
        end else begin
            r_din_q <= din;
            r_prime <= 1'b1;
        end
    end

    // Timestamp counter: counts while enabled, wraps naturally.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ts <= '0;
        end else if (en) begin
            r_ts <= r_ts + C_TS_ONE;
        end
    end

    // FIFO pointer update.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // FIFO storage write; contents are only observable through valid pointers.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_rise, r_ts};
        end
    end

    // Saturating drop counter; a drop coinciding with clear counts as one.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ovf_cnt <= 16'd0;
        end else if (clr_ovf) begin
            r_ovf_cnt <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_ovf_cnt != C_OVF_MAX)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_event_timestamper.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_timestamper
// Description : Self-checking bench for event_timestamper (TW=8, DEPTH=8).
//               Directed table, hand-written corner sequences and a random
//               phase compared against a queue-based reference model.
//               Honours EVENT_TIMESTAMPER_FALLING_EDGE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_timestamper;

    localparam int TW    = 8;
    localparam int DEPTH = 8;

    logic          aclk     = 1'b0;
    logic          areset   = 1'b1;
    logic          din      = 1'b0;
    logic          en       = 1'b0;
    logic          m_tready = 1'b0;
    logic          clr_ovf  = 1'b0;
    logic [TW:0]   m_tdata;
    logic          m_tvalid;
    logic [15:0]   ovf_cnt;

    int checks   = 0;
    int failures = 0;

    event_timestamper #(.TW(TW), .DEPTH(DEPTH)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .din      (din),
        .en       (en),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .clr_ovf  (clr_ovf),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 aclk = ~aclk;

    // Reference model state
    logic [TW-1:0] mdl_ts    = '0;
    logic          mdl_dinq  = 1'b0;
    logic          mdl_prime = 1'b0;
    logic [TW:0]   mdl_q[$];
    int            mdl_ovf   = 0;

    typedef struct {
        logic        din;
        logic        en;
        logic        rdy;
        logic        clr;
        logic        valid;
        logic [TW:0] data;
        logic [15:0] ovf;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_ts    = '0;
        mdl_dinq  = 1'b0;
        mdl_prime = 1'b0;
        mdl_q.delete();
        mdl_ovf   = 0;
    endtask

    // One clock edge of the event-queue rules, evaluated on bench inputs.
    task automatic model_step();
        bit pop, rise, fall, push, drop;
        if (areset) begin
            model_reset();
            return;
        end
        pop  = (mdl_q.size() > 0) && m_tready;
        rise = mdl_prime && din && !mdl_dinq;
`ifdef EVENT_TIMESTAMPER_FALLING_EDGE_EN
        fall = mdl_prime && !din && mdl_dinq;
`else
        fall = 1'b0;
`endif
        push = 1'b0;
        drop = 1'b0;
        if (en && (rise || fall)) begin
            if (mdl_q.size() < DEPTH || pop) push = 1'b1;
            else drop = 1'b1;
        end
        if (pop) void'(mdl_q.pop_front());
        if (push) mdl_q.push_back({rise, mdl_ts});
        if (clr_ovf) mdl_ovf = drop ? 1 : 0;
        else if (drop && mdl_ovf < 65535) mdl_ovf++;
        if (en) mdl_ts = mdl_ts + 1'b1;
        mdl_dinq  = din;
        mdl_prime = 1'b1;
    endtask

    // First half of a cycle: sample outputs on the falling edge against the model.
    task automatic half_a();
        @(negedge aclk);
        chk("mdl_valid", {31'd0, m_tvalid}, {31'd0, (mdl_q.size() > 0)});
        if (mdl_q.size() > 0) chk("mdl_data", 32'(m_tdata), 32'(mdl_q[0]));
        chk("mdl_ovf", 32'(ovf_cnt), mdl_ovf);
    endtask

    // Second half: rising edge, model update, then inputs may change.
    task automatic half_b();
        @(posedge aclk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic drain();
        din = 1'b0; en = 1'b0; m_tready = 1'b1; clr_ovf = 1'b0;
        repeat (DEPTH + 2) cycle();
    endtask

    task automatic run_to_ts(input logic [TW-1:0] target);
        din = 1'b0; en = 1'b1; m_tready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (mdl_ts == target) break;
            cycle();
        end
        chk("reach_ts", 32'(mdl_ts), 32'(target));
    endtask

    initial begin
        logic [TW-1:0] t0;
        logic [TW-1:0] te;

        // din, en, rdy, clr, exp valid, exp data, exp ovf
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 16'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h102, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h102, 16'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 16'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 16'd0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 16'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 16'd0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 16'd0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'h106, 16'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 16'd0};

        // Reset for 30 cycles with din held high through release.
        model_reset();
        areset = 1'b1; din = 1'b1; en = 1'b1;
        repeat (29) cycle();
        half_a();
        chk("rst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_data", 32'(m_tdata), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        half_b();
        areset = 1'b0;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            din = tbl[i].din; en = tbl[i].en; m_tready = tbl[i].rdy; clr_ovf = tbl[i].clr;
            half_a();
            chk($sformatf("tbl%0d_valid", i), {31'd0, m_tvalid}, {31'd0, tbl[i].valid});
            if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), 32'(m_tdata), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf_cnt), 32'(tbl[i].ovf));
            half_b();
        end
        clr_ovf = 1'b0;

        // Overflow: 10 rises into an 8-deep FIFO with no consumer.
        drain();
        m_tready = 1'b0;
        t0 = mdl_ts;
        for (int i = 0; i < 10; i++) begin
            din = 1'b1; en = 1'b1; cycle();
            din = 1'b0; en = 1'b0; cycle();
        end
        half_a();
        chk("ovf_two", 32'(ovf_cnt), 32'd2);
        chk("ovf_head", 32'(m_tdata), 32'({1'b1, t0}));
        half_b();

        // Full FIFO with an edge coincident with a pop.
        din = 1'b1; en = 1'b1; m_tready = 1'b1;
        half_a();
        chk("full_valid", {31'd0, m_tvalid}, 32'd1);
        half_b();
        din = 1'b0; en = 1'b0; m_tready = 1'b0; clr_ovf = 1'b1;
        half_a();
        chk("coinc_ovf", 32'(ovf_cnt), 32'd2);
        half_b();
        clr_ovf = 1'b0;
        half_a();
        chk("clr_ovf", 32'(ovf_cnt), 32'd0);
        half_b();

        // Drain: exactly 8 entries, oldest first.
        m_tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            te = (i < DEPTH - 1) ? t0 + TW'(i + 1) : t0 + TW'(10);
            half_a();
            chk($sformatf("drain%0d_valid", i), {31'd0, m_tvalid}, 32'd1);
            chk($sformatf("drain%0d_data", i), 32'(m_tdata), 32'({1'b1, te}));
            half_b();
        end
        half_a();
        chk("drain_empty", {31'd0, m_tvalid}, 32'd0);
        half_b();

        // Timestamp wrap: edges at 254 and at 3 after wrapping.
        run_to_ts(8'd254);
        din = 1'b1; cycle();
        din = 1'b0; en = 1'b0; cycle();
        run_to_ts(8'd3);
        din = 1'b1; cycle();
        din = 1'b0; en = 1'b0; m_tready = 1'b1;
        half_a();
        chk("wrap_first", 32'(m_tdata), 32'h1FE);
        half_b();
        half_a();
        chk("wrap_second", 32'(m_tdata), 32'h103);
        half_b();
        half_a();
        chk("wrap_empty", {31'd0, m_tvalid}, 32'd0);
        half_b();

        // 14-cycle pulse starting at ts=100.
        run_to_ts(8'd100);
        din = 1'b1;
        repeat (14) cycle();
        din = 1'b0;
        cycle();
        en = 1'b0; m_tready = 1'b1;
        half_a();
        chk("pulse_rise", 32'(m_tdata), 32'h164);
        half_b();
        half_a();
`ifdef EVENT_TIMESTAMPER_FALLING_EDGE_EN
        chk("pulse_fall_valid", {31'd0, m_tvalid}, 32'd1);
        chk("pulse_fall", 32'(m_tdata), 32'h072);
`else
        chk("pulse_no_fall", {31'd0, m_tvalid}, 32'd0);
`endif
        half_b();
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) din = ~din;
            en       = ($urandom_range(0, 9) != 0);
            m_tready = ($urandom_range(0, 2) == 0);
            clr_ovf  = ($urandom_range(0, 49) == 0);
            cycle();
        end

        // Asynchronous reset while events are queued.
        clr_ovf = 1'b0; m_tready = 1'b0; en = 1'b1;
        din = 1'b0; cycle();
        din = 1'b1; cycle();
        din = 1'b0; en = 1'b0; cycle();
        #2 areset = 1'b1;
        #1;
        chk("async_valid", {31'd0, m_tvalid}, 32'd0);
        chk("async_data", 32'(m_tdata), 32'd0);
        chk("async_ovf", 32'(ovf_cnt), 32'd0);
        model_reset();
        din = 1'b1;
        repeat (3) cycle();
        areset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) din = ~din;
            en       = ($urandom_range(0, 9) != 0);
            m_tready = ($urandom_range(0, 1) == 0);
            clr_ovf  = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
